// File: rtl/friscv_rd_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package friscv_rdarb_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REQ_CTRL = 0;
    localparam int unsigned REQ_ALU  = 1;
    localparam logic [4:0]  REG_X0   = 5'h0;

    typedef enum logic {
        LAST_CTRL = 1'b0,
        LAST_ALU  = 1'b1
    } rr_last_e;

    typedef struct packed {
        logic            valid;
        logic [4:0]      addr;
        logic [XLEN-1:0] val;
    } rd_req_t;

    // A valid write to x0 is absorbed without touching the write port.
    function automatic logic is_x0(input rd_req_t req);
        return req.valid && (req.addr == REG_X0);
    endfunction

endpackage

// File: rtl/friscv_rd_arbiter_if.sv
// Request/grant bundle between the two rd requesters, the arbiter and the register file.
interface friscv_rd_arbiter_if;
    import friscv_rdarb_pkg::*;

    logic            ctrl_rd_valid;
    logic            ctrl_rd_ready;
    logic [4:0]      ctrl_rd_addr;
    logic [XLEN-1:0] ctrl_rd_val;
    logic            alu_rd_valid;
    logic            alu_rd_ready;
    logic [4:0]      alu_rd_addr;
    logic [XLEN-1:0] alu_rd_val;
    logic            rd_wr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_val;

    modport master (
        output ctrl_rd_valid, ctrl_rd_addr, ctrl_rd_val,
        output alu_rd_valid, alu_rd_addr, alu_rd_val,
        input  ctrl_rd_ready, alu_rd_ready,
        input  rd_wr, rd_addr, rd_val
    );

    modport slave (
        input  ctrl_rd_valid, ctrl_rd_addr, ctrl_rd_val,
        input  alu_rd_valid, alu_rd_addr, alu_rd_val,
        output ctrl_rd_ready, alu_rd_ready,
        output rd_wr, rd_addr, rd_val
    );

endinterface

// File: rtl/friscv_rd_arbiter_rr.sv
// Two-way round-robin grant with the 1-bit "last granted" pointer.
module friscv_rr_arbiter2
    import friscv_rdarb_pkg::*;
(
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       srst,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    rr_last_e r_last;

    always_comb begin
        o_grant = '0;
        if (i_req[REQ_CTRL] && i_req[REQ_ALU]) begin
            if (r_last == LAST_ALU) begin
                o_grant[REQ_CTRL] = 1'b1;
            end else begin
                o_grant[REQ_ALU] = 1'b1;
            end
        end else begin
            o_grant = i_req;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_last <= LAST_ALU;
        end else if (srst) begin
            r_last <= LAST_ALU;
        end else if (o_grant[REQ_CTRL]) begin
            r_last <= LAST_CTRL;
        end else if (o_grant[REQ_ALU]) begin
            r_last <= LAST_ALU;
        end
    end

endmodule

// File: rtl/friscv_rd_arbiter.sv
// Register-file write-port arbiter: x0 absorption, round-robin grant, payload mux.
// Define FRISCV_RDARB_PIPE_EN to register rd_wr/rd_addr/rd_val (one extra cycle of latency).
module friscv_rd_arbiter
    import friscv_rdarb_pkg::*;
(
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               srst,
    friscv_rd_arbiter_if.slave rd_if
);

    rd_req_t         w_ctrl;
    rd_req_t         w_alu;
    logic            w_live;
    logic            w_ctrl_x0;
    logic            w_alu_x0;
    logic [1:0]      w_req;
    logic [1:0]      w_grant;
    logic            w_wr;
    logic [4:0]      w_addr;
    logic [XLEN-1:0] w_val;

    assign w_ctrl    = {rd_if.ctrl_rd_valid, rd_if.ctrl_rd_addr, rd_if.ctrl_rd_val};
    assign w_alu     = {rd_if.alu_rd_valid, rd_if.alu_rd_addr, rd_if.alu_rd_val};
    // No handshake may complete while either reset is active.
    assign w_live    = aresetn && !srst;
    assign w_ctrl_x0 = is_x0(w_ctrl);
    assign w_alu_x0  = is_x0(w_alu);

    always_comb begin
        w_req           = '0;
        w_req[REQ_CTRL] = w_live && w_ctrl.valid && !w_ctrl_x0;
        w_req[REQ_ALU]  = w_live && w_alu.valid && !w_alu_x0;
    end

    friscv_rr_arbiter2 u_rr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    assign rd_if.ctrl_rd_ready = w_live && (w_ctrl_x0 || w_grant[REQ_CTRL]);
    assign rd_if.alu_rd_ready  = w_live && (w_alu_x0 || w_grant[REQ_ALU]);

    always_comb begin
        w_wr   = 1'b0;
        w_addr = '0;
        w_val  = '0;
        if (w_grant[REQ_CTRL]) begin
            w_wr   = 1'b1;
            w_addr = w_ctrl.addr;
            w_val  = w_ctrl.val;
        end else if (w_grant[REQ_ALU]) begin
            w_wr   = 1'b1;
            w_addr = w_alu.addr;
            w_val  = w_alu.val;
        end
    end

`ifdef FRISCV_RDARB_PIPE_EN
    logic            r_rd_wr;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_rd_val;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_wr   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_val  <= '0;
        end else if (srst) begin
            r_rd_wr   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_val  <= '0;
        end else begin
            r_rd_wr   <= w_wr;
            r_rd_addr <= w_addr;
            r_rd_val  <= w_val;
        end
    end

    assign rd_if.rd_wr   = r_rd_wr;
    assign rd_if.rd_addr = r_rd_addr;
    assign rd_if.rd_val  = r_rd_val;
`else
    assign rd_if.rd_wr   = w_wr;
    assign rd_if.rd_addr = w_addr;
    assign rd_if.rd_val  = w_val;
`endif

endmodule

// File: doc/friscv_rd_arbiter.md
# friscv_rd_arbiter

Write-port arbiter for the integer register file. It accepts destination-register write requests from the control unit and the ALU over valid/ready handshakes. It grants one request per cycle to the register file's single write port using round-robin fairness. Requests targeting x0 are absorbed without consuming the port. It sits between the control unit and ALU and the register file write port.

## Interface
- XLEN, 32, register width
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset
- ctrl_rd_valid  in  1  control unit write request
- ctrl_rd_ready  out  1  control unit request accepted this cycle
- ctrl_rd_addr  in  5  control unit destination register
- ctrl_rd_val  in  XLEN  control unit write data
- alu_rd_valid  in  1  ALU write request
- alu_rd_ready  out  1  ALU request accepted this cycle
- alu_rd_addr  in  5  ALU destination register
- alu_rd_val  in  XLEN  ALU write data
- rd_wr  out  1  register file write enable
- rd_addr  out  5  register file write address
- rd_val  out  XLEN  register file write data

## Operation
- Transfer on a requester occurs when its valid and ready are both high at a rising edge of aclk.
- Requester payload (addr, val) must stay stable while valid is high and ready is low.
- x0 requests (addr == 0):
  - ready is asserted in the same cycle, unconditionally.
  - The request never drives rd_wr and never takes part in arbitration.
  - It does not update the round-robin pointer.
- Only one requester valid with a non-zero address: that requester is granted, and its ready is high in the same cycle.
- Both requesters valid with non-zero addresses: the requester not granted last wins.
  - The losing requester's ready stays low; it must hold its request.
  - The losing requester is granted on the next cycle, guaranteed by the pointer update.
- Both requesters valid with the same non-zero address: arbitrated as above, giving two sequential writes. The last granted value persists.
- Round-robin pointer `last` (1 bit, 0 = ctrl, 1 = alu):
  - Updated on every non-x0 grant.
  - Reset value 1, so ctrl wins the first contention.
- Grant output: rd_wr = 1, rd_addr and rd_val from the granted requester.
- No grant: rd_wr = 0, and rd_addr/rd_val are 0.
- Reset (aresetn low, or srst high at an edge):
  - Both readies low.
  - rd_wr = 0, rd_addr = 0, rd_val = 0.
  - `last` = 1, and any pipeline register is cleared.
  - A request pending at reset is not written; the requester re-presents it after reset.

## Timing
- Without pipeline: ready and rd_wr/rd_addr/rd_val are combinational from valid, addr and `last`.
  - The register file captures at the same edge as the handshake.
  - Write-to-read visibility is 1 cycle after the handshake.
- With pipeline (see Configuration): the output is registered.
  - rd_wr is asserted exactly 1 cycle after the handshake edge.
  - The register file captures 1 cycle later; write-to-read visibility is 2 cycles.
  - ready remains combinational, with no backpressure from the output stage because it drains every cycle.
- Throughput: 1 non-x0 write per cycle. Any x0 requests in the same cycle are also absorbed.
- Fairness: under continuous contention, grants alternate ctrl, alu, ctrl, alu, and so on.
- Each requester's maximum wait is 1 cycle.

## Configuration
- FRISCV_RDARB_PIPE_EN defined:
  - The output stage is registered (rd_wr, rd_addr, rd_val are flops).
  - Reset value is 0; it is cleared by aresetn and srst.
  - Adds 1 cycle of latency.
- Not defined: the outputs are purely combinational from the grant logic, with zero latency.
- The arbitration and handshake behaviour is identical in both builds.

## Structure
- Shared package friscv_rdarb_pkg holds:
  - constants REQ_CTRL = 0, REQ_ALU = 1, REG_X0 = 5'h0;
  - typedef rd_req_t, a struct with valid, addr[4:0] and val[XLEN-1:0].
- Sub-module friscv_rr_arbiter2 holds the 2-way round-robin grant logic and the `last` pointer register.
  - It takes aclk, aresetn and srst, and its inputs are the qualified (non-x0) requests.
  - Its outputs are one-hot grant[1:0].
- The top level contains the x0 filtering, the payload mux, the ready generation and the optional output register.

## Test plan
- Single ctrl write:
  - Stimulus: ctrl_rd_valid = 1, addr = 5, val = 0xDEADBEEF, alu idle.
  - Response: ctrl_rd_ready = 1 in the same cycle; rd_wr = 1, rd_addr = 5, rd_val = 0xDEADBEEF (1 cycle later with FRISCV_RDARB_PIPE_EN).
- Contention:
  - Stimulus: both valid, ctrl addr = 3 / val = 0x11, alu addr = 4 / val = 0x22, held; first contention after reset.
  - Response: ctrl is granted first (rd_addr = 3), then alu the next cycle (rd_addr = 4); readies alternate 1/0 then 0/1.
- x0 absorption:
  - Stimulus: alu_rd_valid with addr = 0 / val = 0xFFFFFFFF, plus ctrl valid with addr = 7 / val = 0x55 in the same cycle.
  - Response: both readies = 1; rd_wr = 1, rd_addr = 7, rd_val = 0x55; no write to address 0; `last` = 0.
- Same address:
  - Stimulus: ctrl and alu both target addr 9, values 0xA and 0xB.
  - Response: two consecutive writes to 9 in round-robin order.
- Sustained contention:
  - Stimulus: 100 cycles of both requesters valid with distinct non-zero addresses.
  - Response: exactly 50 grants each, strictly alternating.
- Reset mid-operation:
  - Stimulus: aresetn asserted while both requesters are contending; then srst pulsed for 1 cycle during alu valid.
  - Response: readies = 0 and rd_wr = 0 during reset; ctrl wins the first contention after reset; no write is issued in the srst cycle.
